// File: rtl/jam_perm_sequencer.sv
// jam_perm_sequencer
//   Enumerates every permutation of N job indices exactly once, in
//   lexicographic order (worker 0 is the most significant position). Each
//   permutation is offered on a valid/ready handshake. Between two
//   permutations the next one is derived with the classic
//   pivot / successor / swap / reverse steps, one step per state.
// Ports
//   CLK         clock, rising edge
//   RST         asynchronous reset, active-high
//   start       1-cycle request to begin a full enumeration (ignored while busy)
//   perm_valid  perm holds a permutation offered to downstream
//   perm_ready  downstream accepts perm this cycle
//   perm        perm[w*IDXW +: IDXW] = job assigned to worker w
//   perm_last   qualifies perm_valid: final (strictly descending) permutation
//   perm_count  accepted handshakes in the current run
//   busy        high from the cycle after start until done
//   done        1-cycle pulse the cycle after the last handshake
module jam_perm_sequencer #(
  parameter int N    = 8,
  parameter int IDXW = 3,
  parameter int CNTW = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  output logic                perm_valid,
  input  logic                perm_ready,
  output logic [N*IDXW-1:0]   perm,
  output logic                perm_last,
  output logic [CNTW-1:0]     perm_count,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE, S_EMIT, S_PIVOT, S_SUCC, S_SWAP, S_REV, S_DONE
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
  localparam logic [IDXW-1:0] ONE      = IDXW'(1);

  state_t              state_q, state_d;
  logic [IDXW-1:0]     p_q [N];
  logic [IDXW-1:0]     p_d [N];
  logic [IDXW-1:0]     k_q, k_d, l_q, l_d, i_q, i_d, j_q, j_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;

  logic [IDXW-1:0]     pivot_idx;
  logic [IDXW-1:0]     succ_idx;
  logic                descending;

  // Combinational searches over the current permutation.
  always_comb begin
    pivot_idx  = '0;
    succ_idx   = '0;
    descending = 1'b1;
    for (int w = 0; w < N - 1; w++) begin
      if (p_q[w] < p_q[w+1]) begin
        pivot_idx = IDXW'(w);
      end
      if (p_q[w] <= p_q[w+1]) begin
        descending = 1'b0;
      end
    end
    for (int w = 0; w < N; w++) begin
      if (w > int'(k_q) && p_q[w] > p_q[k_q]) begin
        succ_idx = IDXW'(w);
      end
    end
  end

  assign perm_valid = (state_q == S_EMIT);
  // Only the final permutation is strictly descending, so PIVOT always finds a pivot.
  assign perm_last  = (state_q == S_EMIT) && descending;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign perm_count = cnt_q;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_perm
      assign perm[gi*IDXW +: IDXW] = p_q[gi];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    k_d     = k_q;
    l_d     = l_q;
    i_d     = i_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int w = 0; w < N; w++) begin
            p_d[w] = IDXW'(w);
          end
          cnt_d   = '0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (perm_ready) begin
          cnt_d   = cnt_q + CNTW'(1);
          state_d = perm_last ? S_DONE : S_PIVOT;
        end
      end
      S_PIVOT: begin
        k_d     = pivot_idx;
        state_d = S_SUCC;
      end
      S_SUCC: begin
        l_d     = succ_idx;
        state_d = S_SWAP;
      end
      S_SWAP: begin
        p_d[k_q] = p_q[l_q];
        p_d[l_q] = p_q[k_q];
        i_d      = k_q + ONE;
        j_d      = LAST_IDX;
        // The suffix after k is descending; it needs reversing only if it has 2+ entries.
        state_d  = ((k_q + ONE) < LAST_IDX) ? S_REV : S_EMIT;
      end
      S_REV: begin
        p_d[i_q] = p_q[j_q];
        p_d[j_q] = p_q[i_q];
        i_d      = i_q + ONE;
        j_d      = j_q - ONE;
        state_d  = ((i_q + ONE) < (j_q - ONE)) ? S_REV : S_EMIT;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      for (int w = 0; w < N; w++) begin
        p_q[w] <= IDXW'(w);
      end
      k_q   <= '0;
      l_q   <= '0;
      i_q   <= '0;
      j_q   <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      k_q     <= k_d;
      l_q     <= l_d;
      i_q     <= i_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_jam_perm_sequencer.sv
// Bench for jam_perm_sequencer: an N=8 instance and an N=3 instance share the
// clock and reset. The reference model ranks permutations with the factorial
// number system and tracks handshake timing from the documented gap rule.
module tb_jam_perm_sequencer;

  logic        CLK;
  logic        RST;
  logic        start0, ready0, valid0, last0, busy0, done0;
  logic [23:0] perm0;
  logic [15:0] count0;
  logic        start1, ready1, valid1, last1, busy1, done1;
  logic [5:0]  perm1;
  logic [15:0] count1;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state per instance (0: N=8, 1: N=3)
  int e_valid[2], e_busy[2], e_done[2], e_rank[2], e_cnt[2], e_gap[2];

  jam_perm_sequencer #(.N(8), .IDXW(3), .CNTW(16)) dut0 (
    .CLK(CLK), .RST(RST), .start(start0), .perm_valid(valid0), .perm_ready(ready0),
    .perm(perm0), .perm_last(last0), .perm_count(count0), .busy(busy0), .done(done0)
  );

  jam_perm_sequencer #(.N(3), .IDXW(2), .CNTW(16)) dut1 (
    .CLK(CLK), .RST(RST), .start(start1), .perm_valid(valid1), .perm_ready(ready1),
    .perm(perm1), .perm_last(last1), .perm_count(count1), .busy(busy1), .done(done1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int fact(input int n);
    int f = 1;
    for (int i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  // Permutation of rank r in lexicographic order, worker 0 most significant.
  function automatic logic [23:0] unrank(input int n, input int w, input int r);
    logic [23:0] res = '0;
    bit used[8];
    int rem = r;
    for (int i = 0; i < 8; i++) used[i] = 1'b0;
    for (int i = 0; i < n; i++) begin
      int f = fact(n - 1 - i);
      int d = rem / f;
      rem = rem % f;
      for (int v = 0; v < n; v++) begin
        if (!used[v]) begin
          if (d == 0) begin
            used[v] = 1'b1;
            res = res | (24'(v) << (i * w));
            d = -1;
          end else if (d > 0) begin
            d--;
          end
        end
      end
    end
    return res;
  endfunction

  function automatic int elem(input logic [23:0] p, input int w, input int i);
    return int'((p >> (i * w)) & ((24'd1 << w) - 24'd1));
  endfunction

  function automatic int pivot(input int n, input int w, input logic [23:0] p);
    int k = -1;
    for (int i = 0; i < n - 1; i++) if (elem(p, w, i) < elem(p, w, i + 1)) k = i;
    return k;
  endfunction

  task automatic model_cycle(input int id, input logic st, input logic rdy, input logic v,
                             input logic b, input logic d, input logic lst,
                             input logic [15:0] cnt, input logic [23:0] p);
    int n = (id == 0) ? 8 : 3;
    int w = (id == 0) ? 3 : 2;
    int last = fact(n) - 1;
    string pre = (id == 0) ? "n8" : "n3";
    if (RST) begin
      chk({pre, ".rst_valid"}, v, 0);
      chk({pre, ".rst_busy"}, b, 0);
      chk({pre, ".rst_done"}, d, 0);
      chk({pre, ".rst_last"}, lst, 0);
      chk({pre, ".rst_count"}, cnt, 0);
      chk({pre, ".rst_perm"}, p, unrank(n, w, 0));
      e_valid[id] = 0; e_busy[id] = 0; e_done[id] = 0;
      e_rank[id] = 0; e_cnt[id] = 0; e_gap[id] = 0;
    end else begin
      chk({pre, ".valid"}, v, e_valid[id]);
      chk({pre, ".busy"}, b, e_busy[id]);
      chk({pre, ".done"}, d, e_done[id]);
      chk({pre, ".count"}, cnt, e_cnt[id]);
      chk({pre, ".last"}, lst, (e_valid[id] != 0 && e_rank[id] == last) ? 1 : 0);
      if (e_valid[id] != 0) chk({pre, ".perm"}, p, unrank(n, w, e_rank[id]));
      if (e_done[id] != 0) chk({pre, ".done_perm"}, p, unrank(n, w, last));
      // advance to the next cycle
      if (e_done[id] != 0) begin
        e_done[id] = 0;
      end else if (e_busy[id] == 0) begin
        if (st) begin
          e_busy[id] = 1; e_valid[id] = 1; e_rank[id] = 0; e_cnt[id] = 0;
        end
      end else if (e_valid[id] != 0) begin
        if (rdy) begin
          e_cnt[id]++;
          e_valid[id] = 0;
          if (e_rank[id] == last) begin
            e_busy[id] = 0;
            e_done[id] = 1;
          end else begin
            e_gap[id] = 3 + (n - 1 - pivot(n, w, unrank(n, w, e_rank[id]))) / 2;
            e_rank[id]++;
          end
        end
      end else begin
        e_gap[id]--;
        if (e_gap[id] <= 0) e_valid[id] = 1;
      end
    end
  endtask

  always @(negedge CLK) begin
    model_cycle(0, start0, ready0, valid0, busy0, done0, last0, count0, perm0);
    model_cycle(1, start1, ready1, valid1, busy1, done1, last1, count1, 24'(perm1));
  end

  logic [5:0] tbl3 [6];
  int cyc, hold, pulsed, idx, dones;

  initial begin
    RST = 1'b1;
    start0 = 0; ready0 = 0; start1 = 0; ready1 = 0;
    tbl3 = '{6'h24, 6'h18, 6'h21, 6'h09, 6'h12, 6'h06};

    // Literal pins for the model itself
    chk("pin_rank0", unrank(8, 3, 0), 24'hFAC688);
    chk("pin_rank1", unrank(8, 3, 1), 24'hDEC688);
    chk("pin_rank_last", unrank(8, 3, 40319), 24'h053977);
    chk("pin_pivot0", pivot(8, 3, unrank(8, 3, 0)), 6);
    for (int r = 0; r < 6; r++) chk($sformatf("pin_n3_rank%0d", r), unrank(3, 2, r), tbl3[r]);

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("idle_perm", perm0, 24'hFAC688);
    chk("idle_count", count0, 0);
    chk("idle_valid", valid0, 0);

    // Run A: random backpressure, start re-pulse at #100, reset at #500
    start0 = 1;
    @(posedge CLK); #1;
    start0 = 0;
    chk("first_valid", valid0, 1);
    chk("first_perm", perm0, 24'hFAC688);
    cyc = 0; hold = 0; pulsed = 0;
    while (e_cnt[0] < 500 && cyc < 20000) begin
      ready0 = ($urandom_range(0, 3) != 0);
      if (e_cnt[0] == 1 && e_valid[0] != 0 && hold < 5) begin
        ready0 = 0;
        hold++;
        if (hold == 5) chk("stall_count", count0, 1);
      end
      start0 = (e_cnt[0] == 100 && pulsed == 0);
      if (start0) pulsed = 1;
      @(posedge CLK); #1;
      cyc++;
    end
    start0 = 0;
    chk("runA_in_budget", (cyc < 20000) ? 1 : 0, 1);
    RST = 1'b1;
    ready0 = 0;
    #1;
    chk("async_rst_valid", valid0, 0);
    chk("async_rst_perm", perm0, 24'hFAC688);
    chk("async_rst_count", count0, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (5) @(posedge CLK);
    #1;

    // Run B: fresh start after reset, restarts from identity
    start0 = 1;
    @(posedge CLK); #1;
    start0 = 0;
    chk("restart_perm", perm0, 24'hFAC688);
    cyc = 0;
    while (e_cnt[0] < 40 && cyc < 2000) begin
      ready0 = ($urandom_range(0, 7) != 0);
      @(posedge CLK); #1;
      cyc++;
    end
    ready0 = 0;
    chk("runB_in_budget", (cyc < 2000) ? 1 : 0, 1);

    // Run C: N=3 full run with random ready, start during DONE is ignored
    start1 = 1;
    @(posedge CLK); #1;
    start1 = 0;
    cyc = 0;
    while (e_done[1] == 0 && cyc < 500) begin
      ready1 = ($urandom_range(0, 2) != 0);
      @(posedge CLK); #1;
      cyc++;
    end
    chk("runC_in_budget", (cyc < 500) ? 1 : 0, 1);
    start1 = 1;
    @(posedge CLK); #1;
    start1 = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("n3_start_in_done_ignored", busy1, 0);
    chk("n3_final_count", count1, 6);

    // Run D: N=3 full run, ready=1, order against the literal table
    ready1 = 1;
    start1 = 1;
    @(posedge CLK); #1;
    start1 = 0;
    idx = 0; dones = 0; cyc = 0;
    while (dones == 0 && cyc < 200) begin
      if (valid1) begin
        if (idx < 6) chk($sformatf("n3_order%0d", idx), perm1, tbl3[idx]);
        idx++;
      end
      if (done1) dones++;
      @(posedge CLK); #1;
      cyc++;
    end
    chk("runD_in_budget", (cyc < 200) ? 1 : 0, 1);
    chk("n3_transfers", idx, 6);
    chk("n3_count", count1, 6);
    repeat (4) begin
      if (done1) dones++;
      @(posedge CLK); #1;
    end
    chk("n3_done_once", dones, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
